// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the boot-time instruction memory loader: the FSM
// state encoding and the framing constants used by the loader and its
// byte packer.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR_LO  = 3'd0,
        ST_HDR_HI  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_WRITE   = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_loader_byte_packer
// Packs incoming stream bytes little-endian into one memory word and keeps
// the running XOR checksum of every byte loaded since the last clear.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   i_load       store i_byte into the current lane and fold it into the sum
//   i_clear      restart lane counter and checksum (new frame)
//   i_byte       stream byte
//   o_word       packed word, lane 0 in the low bits
//   o_word_full  this load fills the last lane of the word
//   o_checksum   XOR of all bytes loaded since clear/reset
// ---------------------------------------------------------------------------
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int ADD_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_load,
    input  logic                                i_clear,
    input  logic [ADD_WIDTH-1:0]                i_byte,
    output logic [BYTES_PER_WORD*ADD_WIDTH-1:0] o_word,
    output logic                                o_word_full,
    output logic [ADD_WIDTH-1:0]                o_checksum
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic [IDX_W-1:0]                  r_byte_idx;
    logic [BYTES_PER_WORD*ADD_WIDTH-1:0] r_word;
    logic [ADD_WIDTH-1:0]              r_checksum;

    // The lane index wraps naturally because BYTES_PER_WORD is a power of two.
    // The word itself is not cleared: every lane is rewritten before use.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_idx <= '0;
            r_word     <= '0;
            r_checksum <= '0;
        end else if (i_clear) begin
            r_byte_idx <= '0;
            r_checksum <= '0;
        end else if (i_load) begin
            r_word[r_byte_idx*ADD_WIDTH +: ADD_WIDTH] <= i_byte;
            r_byte_idx <= r_byte_idx + IDX_ONE;
            r_checksum <= r_checksum ^ i_byte;
        end
    end

    assign o_word      = r_word;
    assign o_word_full = i_load && (r_byte_idx == LAST_LANE);
    assign o_checksum  = r_checksum;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the instruction memory. Accepts a framed byte stream
// (2-byte word count, 4*count payload bytes, XOR checksum byte), writes one
// 32-bit word per 4 payload bytes and releases the core once the checksum
// matches.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   rx_data    stream byte
//   rx_valid   rx_data is valid
//   rx_ready   loader accepts a byte this cycle
//   mem_addr   byte address of the word write (multiple of 4)
//   mem_wdata  packed word, byte at mem_addr in [7:0]
//   mem_we     one-cycle word write strobe
//   core_hold  1 keeps the core in reset
//   done       image loaded and verified (sticky)
//   error      oversize image or checksum mismatch (sticky)
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADD_WIDTH = 8,
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADD_WIDTH-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_we,
    output logic                 core_hold,
    output logic                 done,
    output logic                 error
);

    localparam int MAX_WORDS = REG_WIDTH / BYTES_PER_WORD;
    localparam int WIDX_W    = $clog2(MAX_WORDS + 1);
    localparam logic [15:0]       MAX_WORDS_C = 16'(MAX_WORDS);
    localparam logic [WIDX_W-1:0] WIDX_ONE    = WIDX_W'(1);

    state_t r_state;
    state_t w_next_state;

    logic                 r_live;
    logic [ADD_WIDTH-1:0] r_count_lo;
    logic [15:0]          r_count;
    logic [WIDX_W-1:0]    r_word_idx;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;

    logic                 w_xfer;
    logic                 w_load;
    logic                 w_clear;
    logic                 w_word_full;
    logic [31:0]          w_word;
    logic [ADD_WIDTH-1:0] w_checksum;
    logic [15:0]          w_count_hdr;
    logic [15:0]          w_next_word_idx;
    logic [31:0]          w_wr_addr;

    imem_loader_byte_packer #(
        .ADD_WIDTH (ADD_WIDTH)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_clear     (w_clear),
        .i_byte      (rx_data),
        .o_word      (w_word),
        .o_word_full (w_word_full),
        .o_checksum  (w_checksum)
    );

    assign w_xfer          = rx_valid && rx_ready;
    assign w_load          = w_xfer && (r_state == ST_PAYLOAD);
    assign w_clear         = (r_state == ST_HDR_LO);
    assign w_count_hdr     = 16'({rx_data, r_count_lo});
    assign w_next_word_idx = 16'(r_word_idx) + 16'd1;
    assign w_wr_addr       = 32'(r_word_idx) << 2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_HDR_LO;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_live keeps rx_ready low while reset is asserted even though the
    // state register already sits in HDR_LO; it rises on the first edge.
    // The memory port registers capture the write so they hold afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live      <= 1'b0;
            r_count_lo  <= '0;
            r_count     <= '0;
            r_word_idx  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_live <= 1'b1;
            if (r_state == ST_HDR_LO && w_xfer) begin
                r_count_lo <= rx_data;
            end
            if (r_state == ST_HDR_HI && w_xfer) begin
                r_count <= w_count_hdr;
            end
            if (r_state == ST_WRITE) begin
                r_word_idx  <= r_word_idx + WIDX_ONE;
                r_mem_addr  <= w_wr_addr;
                r_mem_wdata <= w_word;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_HDR_LO: begin
                if (w_xfer) w_next_state = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (w_xfer) begin
                    if (w_count_hdr > MAX_WORDS_C) begin
                        w_next_state = ST_ERROR;
                    end else if (w_count_hdr == 16'd0) begin
                        w_next_state = ST_CHECK;
                    end else begin
                        w_next_state = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_word_full) w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                w_next_state = (w_next_word_idx == r_count) ? ST_CHECK : ST_PAYLOAD;
            end
            ST_CHECK: begin
                if (w_xfer) w_next_state = (rx_data == w_checksum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE:  w_next_state = ST_DONE;
            ST_ERROR: w_next_state = ST_ERROR;
            default:  w_next_state = ST_ERROR;
        endcase
    end

    // Outside WRITE the port shows the last write so memory sees stable values.
    always_comb begin
        rx_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_mem_addr;
        mem_wdata = r_mem_wdata;
        case (r_state)
            ST_HDR_LO, ST_HDR_HI, ST_PAYLOAD, ST_CHECK: rx_ready = r_live;
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = w_wr_addr;
                mem_wdata = w_word;
            end
            default: rx_ready = 1'b0;
        endcase
    end

    assign done      = (r_state == ST_DONE);
    assign error     = (r_state == ST_ERROR);
    assign core_hold = (r_state != ST_DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the byte-addressed instruction memory.
- Consumes a framed byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Issues one word write per 4 bytes and verifies an XOR checksum.
- Holds the core in reset until the image is loaded; sits between the host byte source and the instruction memory write port.

Parameters:
- ADD_WIDTH, 8: memory cell width in bits (one byte per cell).
- REG_WIDTH, 32: memory depth in bytes. Maximum image size is REG_WIDTH/4 words.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  ADD_WIDTH  incoming stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte this cycle.
- mem_addr  out  32  byte address of the word write; always a multiple of 4.
- mem_wdata  out  32  packed word; byte at mem_addr is in [7:0].
- mem_we  out  1  one-cycle word write strobe.
- core_hold  out  1  1 holds the core in reset.
- done  out  1  load completed successfully; sticky.
- error  out  1  load failed; sticky.

Behaviour:
- Frame format:
  - Byte 0: count_lo. Byte 1: count_hi. Word count = {count_hi, count_lo}.
  - Next 4*count payload bytes, least-significant byte of each word first.
  - Final byte: checksum = XOR of all payload bytes. Header bytes are not included.
- Transfer rule: a byte transfers on a rising edge with rx_valid=1 and rx_ready=1. No transfer otherwise. rx_data is ignored when no transfer occurs.
- States:
  - HDR_LO, HDR_HI, PAYLOAD, CHECK: rx_ready=1.
  - WRITE, DONE, ERROR: rx_ready=0.
- HDR_LO -> HDR_HI on transfer; count_lo is latched.
- HDR_HI, on transfer:
  - count > REG_WIDTH/4 -> ERROR.
  - count == 0 -> CHECK.
  - Otherwise -> PAYLOAD.
- PAYLOAD:
  - Each transfer stores the byte into lane byte_idx (bits 8*byte_idx+7 : 8*byte_idx) and XORs it into the checksum.
  - byte_idx increments modulo 4.
  - The 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr = word_idx*4, mem_wdata = packed word.
  - Next cycle word_idx++. If the new word_idx == count -> CHECK, else -> PAYLOAD.
  - Peak throughput is 4 bytes per 5 cycles.
- CHECK, on transfer: byte == running checksum -> DONE, else -> ERROR.
- DONE: done=1, core_hold=0. Stays until reset; further rx_valid is ignored.
- ERROR: error=1, core_hold=1. Stays until reset.
- mem_addr and mem_wdata hold their last values while mem_we=0. mem_we is never asserted outside WRITE.
- Output values while reset is asserted: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, done=0, error=0.
- Output values after reset is released: state HDR_LO, so rx_ready=1 from the first clock edge.
- Reset mid-operation: aborts immediately. word_idx, byte_idx, count and checksum return to 0; state returns to HDR_LO. Memory contents already written are not cleared.
- Word addressing: word_idx is wide enough for REG_WIDTH/4. The count comparison uses the full 16-bit value, so there is no wrap-around and the write address never exceeds REG_WIDTH-4.

Decomposition:
- Shared package holds:
  - state encoding constants for the seven states;
  - BYTES_PER_WORD=4;
  - HDR_BYTES=2.
- One natural sub-module: byte_packer.
  - Handles the byte lane shift, byte_idx counter and running XOR checksum.
  - Interface: load/clear in; word, word_full and checksum out.
- The FSM, counters and memory-port registers stay in imem_loader.

Test Plan:
- Reset: drive reset=0 with rx_valid=1 -> rx_ready=0, mem_we=0, core_hold=1, done=0, error=0. Release reset -> rx_ready=1 on the next clock.
- Good 2-word load, stream 02 00 13 00 50 00 93 00 A0 00 70:
  - mem_we pulses twice: addr 0x0 with wdata 0x00500013, then addr 0x4 with wdata 0x00A00093.
  - Then done=1 and core_hold=0.
- Same stream with a checksum of 71 instead of 70 -> both writes occur, then error=1, core_hold=1, rx_ready=0, done=0.
- Oversize header 09 00 (REG_WIDTH=32) -> ERROR after the second byte; mem_we is never asserted.
- Empty image 00 00 00 -> done=1 and no mem_we.
- Backpressure and gaps:
  - Hold rx_valid=1 through a WRITE cycle -> the byte is not consumed until the next state.
  - Insert random rx_valid=0 gaps -> identical words and addresses to the good 2-word load.
  - Reset mid-payload after 6 bytes, then replay the good 2-word stream -> writes restart at addr 0x0 and done=1.
